// File: rtl/digest_tx_pkg.sv
// Shared types and constants for the digest register-window transmitter.
// DIGEST_TX_BYTESWAP_EN (in digest_tx) byte-reverses each word at capture.
package digest_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_ACKED   = 2'd2
  } state_e;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned WIN_WORDS = 7;
  localparam int unsigned IDX_W     = 4;

  localparam int unsigned STAT_WIN_VALID = 0;
  localparam int unsigned STAT_IDLE      = 1;
  localparam int unsigned STAT_DONE      = 2;
  localparam int unsigned STAT_WIDX_LSB  = 4;

  // SHA big-endian word to CPU little-endian word
  function automatic logic [WORD_W-1:0] bswap32(input logic [WORD_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/digest_tx_winsel.sv
// Registered window selector: maps buffer + window index onto seven slots,
// zero-filling slots past the end of the digest.
module digest_tx_winsel
  import digest_tx_pkg::*;
#(
  parameter int unsigned NWORDS = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WORD_W*NWORDS-1:0]      buf_i,
  input  logic [IDX_W-1:0]              idx_i,
  input  logic                          load_i,
  input  logic                          clear_i,
  output logic [WORD_W*WIN_WORDS-1:0]   slots_o
);

  logic [WORD_W*WIN_WORDS-1:0] slots_d, slots_q;

  always_comb begin
    slots_d = '0;
    for (int unsigned s = 0; s < WIN_WORDS; s++) begin
      if ((WIN_WORDS * 32'(idx_i) + s) < NWORDS) begin
        slots_d[s*WORD_W +: WORD_W] = buf_i[(WIN_WORDS * 32'(idx_i) + s)*WORD_W +: WORD_W];
      end
    end
  end

  // Clear wins over load so an abort always blanks the bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots_q <= '0;
    end else if (clear_i) begin
      slots_q <= '0;
    end else if (load_i) begin
      slots_q <= slots_d;
    end
  end

  assign slots_o = slots_q;

endmodule

// File: rtl/digest_tx.sv
// Digest transmitter: captures a digest over valid/ready and presents it as
// 7-word windows with a four-phase CPU ack. Option: DIGEST_TX_BYTESWAP_EN.
module digest_tx
  import digest_tx_pkg::*;
#(
  parameter int unsigned NWORDS = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [32*NWORDS-1:0]      digest_in,
  input  logic                      digest_valid,
  output logic                      digest_ready,
  input  logic                      cpu_ack,
  input  logic                      cpu_abort,
  output logic [31:0]               rout1,
  output logic [31:0]               rout2,
  output logic [31:0]               rout3,
  output logic [31:0]               rout4,
  output logic [31:0]               rout5,
  output logic [31:0]               rout6,
  output logic [31:0]               rout7,
  output logic [31:0]               status,
  output logic                      tx_done
);

  localparam int unsigned NWIN = (NWORDS + WIN_WORDS - 1) / WIN_WORDS;

  state_e                     state_d, state_q;
  logic [WORD_W*NWORDS-1:0]   buf_d, buf_q, cap_word;
  logic [IDX_W-1:0]           win_idx_d, win_idx_q;
  logic                       done_d, done_q;
  logic                       tx_done_d, tx_done_q;
  logic                       win_valid_q, idle_q;
  logic                       load, clear;
  logic [WORD_W*WIN_WORDS-1:0] slots;

  always_comb begin
    cap_word = '0;
    for (int unsigned k = 0; k < NWORDS; k++) begin
`ifdef DIGEST_TX_BYTESWAP_EN
      cap_word[k*WORD_W +: WORD_W] = bswap32(digest_in[k*WORD_W +: WORD_W]);
`else
      cap_word[k*WORD_W +: WORD_W] = digest_in[k*WORD_W +: WORD_W];
`endif
    end
  end

  // A stale ack or a pending abort blocks capture so window 0 is never skipped
  assign digest_ready = (state_q == S_IDLE) & ~cpu_ack & ~cpu_abort;

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    win_idx_d = win_idx_q;
    done_d    = done_q;
    tx_done_d = 1'b0;
    load      = 1'b0;
    clear     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (digest_valid && digest_ready) begin
          buf_d     = cap_word;
          win_idx_d = '0;
          done_d    = 1'b0;
          load      = 1'b1;
          state_d   = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (cpu_ack) state_d = S_ACKED;
      end
      S_ACKED: begin
        if (!cpu_ack) begin
          if (win_idx_q == IDX_W'(NWIN - 1)) begin
            win_idx_d = '0;
            done_d    = 1'b1;
            tx_done_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            win_idx_d = win_idx_q + IDX_W'(1);
            load      = 1'b1;
            state_d   = S_PRESENT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (cpu_abort) begin
      state_d   = S_IDLE;
      win_idx_d = '0;
      done_d    = 1'b0;
      tx_done_d = 1'b0;
      load      = 1'b0;
      clear     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      win_idx_q   <= '0;
      done_q      <= 1'b0;
      tx_done_q   <= 1'b0;
      win_valid_q <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      win_idx_q   <= win_idx_d;
      done_q      <= done_d;
      tx_done_q   <= tx_done_d;
      win_valid_q <= (state_d == S_PRESENT);
      idle_q      <= (state_d == S_IDLE);
    end
  end

  // Slots are loaded from next-state values so they line up with win_valid
  digest_tx_winsel #(.NWORDS(NWORDS)) u_winsel (
    .clk     (clk),
    .rst_n   (resetn),
    .buf_i   (buf_d),
    .idx_i   (win_idx_d),
    .load_i  (load),
    .clear_i (clear),
    .slots_o (slots)
  );

  always_comb begin
    status                              = '0;
    status[STAT_WIN_VALID]              = win_valid_q;
    status[STAT_IDLE]                   = idle_q;
    status[STAT_DONE]                   = done_q;
    status[STAT_WIDX_LSB +: IDX_W]      = win_idx_q;
  end

  assign rout1   = slots[0*WORD_W +: WORD_W];
  assign rout2   = slots[1*WORD_W +: WORD_W];
  assign rout3   = slots[2*WORD_W +: WORD_W];
  assign rout4   = slots[3*WORD_W +: WORD_W];
  assign rout5   = slots[4*WORD_W +: WORD_W];
  assign rout6   = slots[5*WORD_W +: WORD_W];
  assign rout7   = slots[6*WORD_W +: WORD_W];
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_digest_tx.sv
// Directed self-checking bench for digest_tx with NWORDS = 8 (two windows).
module tb_digest_tx;

  localparam int unsigned NW = 8;

  logic              clk = 1'b0;
  logic              resetn;
  logic [32*NW-1:0]  digest_in;
  logic              digest_valid, digest_ready;
  logic              cpu_ack, cpu_abort;
  logic [31:0]       rout1, rout2, rout3, rout4, rout5, rout6, rout7;
  logic [31:0]       status;
  logic              tx_done;
  logic [31:0]       r [7];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  digest_tx #(.NWORDS(NW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .digest_in    (digest_in),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready),
    .cpu_ack      (cpu_ack),
    .cpu_abort    (cpu_abort),
    .rout1        (rout1),
    .rout2        (rout2),
    .rout3        (rout3),
    .rout4        (rout4),
    .rout5        (rout5),
    .rout6        (rout6),
    .rout7        (rout7),
    .status       (status),
    .tx_done      (tx_done)
  );

  assign r[0] = rout1;
  assign r[1] = rout2;
  assign r[2] = rout3;
  assign r[3] = rout4;
  assign r[4] = rout5;
  assign r[5] = rout6;
  assign r[6] = rout7;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_digest(input logic [31:0] base, input logic [31:0] inc);
    for (int k = 0; k < NW; k++) digest_in[k*32 +: 32] = base + inc * 32'(k);
  endtask

  initial begin
    resetn       = 1'b0;
    cpu_ack      = 1'b0;
    cpu_abort    = 1'b0;
    digest_valid = 1'b0;
    digest_in    = '0;
    #12;
    check("rst_status", status, 32'h2);
    check("rst_rout1", rout1, 32'h0);
    check("rst_rout7", rout7, 32'h0);
    check("rst_txdone", 32'(tx_done), 32'h0);
    check("rst_ready", 32'(digest_ready), 32'h1);
    resetn = 1'b1;
    step();

    // Full transfer: words 0x11111111..0x88888888 (byte-symmetric)
    set_digest(32'h11111111, 32'h11111111);
    digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
    for (int s = 0; s < 7; s++) check($sformatf("w0_rout%0d", s + 1), r[s], 32'h11111111 * 32'(s + 1));
    check("w0_status", status, 32'h01);
    check("w0_ready", 32'(digest_ready), 32'h0);
    cpu_ack = 1'b1;
    step();
    check("w0_acked_status", status, 32'h00);
    check("w0_acked_hold", rout1, 32'h11111111);
    cpu_ack = 1'b0;
    step();
    check("w1_status", status, 32'h11);
    check("w1_rout1", rout1, 32'h88888888);
    for (int s = 1; s < 7; s++) check($sformatf("w1_rout%0d", s + 1), r[s], 32'h0);
    check("w1_txdone", 32'(tx_done), 32'h0);
    cpu_ack = 1'b1;
    step();
    check("w1_acked_status", status, 32'h10);
    cpu_ack = 1'b0;
    step();
    check("done_txdone", 32'(tx_done), 32'h1);
    check("done_status", status, 32'h06);
    step();
    check("done_txdone_drop", 32'(tx_done), 32'h0);
    check("done_status_hold", status, 32'h06);

    // Back-pressure: second digest waits for idle
    set_digest(32'h11111111, 32'h11111111);
    digest_valid = 1'b1;
    step();
    set_digest(32'hA0000000, 32'h1);
    check("bp_w0_status", status, 32'h01);
    check("bp_ready_w0", 32'(digest_ready), 32'h0);
    cpu_ack = 1'b1;
    step();
    check("bp_ready_ack0", 32'(digest_ready), 32'h0);
    cpu_ack = 1'b0;
    step();
    check("bp_ready_w1", 32'(digest_ready), 32'h0);
    check("bp_w1_rout1", rout1, 32'h88888888);
    cpu_ack = 1'b1;
    step();
    cpu_ack = 1'b0;
    step();
    check("bp_txdone", 32'(tx_done), 32'h1);
    check("bp_ready_idle", 32'(digest_ready), 32'h1);
    step();
    digest_valid = 1'b0;
    check("bp_second_status", status, 32'h01);
    check("bp_second_rout1", rout1, 32'hA0000000);
    check("bp_second_rout7", rout7, 32'hA0000006);

    // Abort in ACKED of window 0
    cpu_ack = 1'b1;
    step();
    check("ab_acked_status", status, 32'h00);
    cpu_abort = 1'b1;
    cpu_ack   = 1'b0;
    step();
    cpu_abort = 1'b0;
    check("ab_status", status, 32'h02);
    check("ab_rout1", rout1, 32'h0);
    check("ab_rout7", rout7, 32'h0);
    check("ab_txdone", 32'(tx_done), 32'h0);
    step();
    check("ab_txdone_later", 32'(tx_done), 32'h0);

    // Stale ack in IDLE blocks capture
    set_digest(32'hC0000000, 32'h10);
    cpu_ack      = 1'b1;
    digest_valid = 1'b1;
    step();
    check("stale_status", status, 32'h02);
    check("stale_ready", 32'(digest_ready), 32'h0);
    step();
    check("stale_status2", status, 32'h02);
    cpu_ack = 1'b0;
    step();
    digest_valid = 1'b0;
    check("stale_cap_status", status, 32'h01);
    check("stale_cap_rout1", rout1, 32'hC0000000);
    check("stale_cap_rout2", rout2, 32'hC0000010);

    // Asynchronous reset while presenting
    #3;
    resetn = 1'b0;
    #1;
    check("arst_status", status, 32'h02);
    check("arst_rout1", rout1, 32'h0);
    check("arst_rout3", rout3, 32'h0);
    #2;
    resetn = 1'b1;
    step();
    check("arst_after_status", status, 32'h02);

    // Byte order of captured words
    digest_in            = '0;
    digest_in[31:0]      = 32'hDEADBEEF;
    digest_in[63:32]     = 32'h01234567;
    digest_valid         = 1'b1;
    step();
    digest_valid = 1'b0;
`ifdef DIGEST_TX_BYTESWAP_EN
    check("bswap_rout1", rout1, 32'hEFBEADDE);
    check("bswap_rout2", rout2, 32'h67452301);
`else
    check("bswap_rout1", rout1, 32'hDEADBEEF);
    check("bswap_rout2", rout2, 32'h01234567);
`endif
    check("bswap_status", status, 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
